// File: rtl/pe_ctx_pkg.sv
// ============================================================================
// pe_ctx_pkg : state encoding and sizing defaults shared by the PE context
//              sequencer and the context cache.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package pe_ctx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int CP_W_DEFAULT    = 16;
  localparam int MAX_CTX_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/pe_context_sequencer.sv
// ============================================================================
// pe_context_sequencer : steps the context pointer CP through ctx_len
//                        contexts for iter_cnt sweeps (0 = until abort).
// Optional feature     : PE_CTX_STALL_EN adds a stall input that freezes CP.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module pe_context_sequencer
  import pe_ctx_pkg::*;
#(
  parameter int CP_W    = CP_W_DEFAULT,
  parameter int MAX_CTX = MAX_CTX_DEFAULT,
  parameter int ITER_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_done,
  input  logic              go,
  input  logic [CP_W-1:0]   ctx_len,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic              abort,
`ifdef PE_CTX_STALL_EN
  input  logic              stall,
`endif
  output logic [CP_W-1:0]   CP,
  output logic              ctx_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [CP_W-1:0]   MAX_LEN  = CP_W'(MAX_CTX);
  localparam logic [CP_W-1:0]   CP_ONE   = CP_W'(1);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  state_t            state, state_nxt;
  logic [CP_W-1:0]   len_q, len_nxt;
  logic [ITER_W-1:0] iter_q, iter_nxt;
  logic [ITER_W-1:0] rem_q, rem_nxt;
  logic [CP_W-1:0]   cp_nxt;
  logic              busy_nxt, valid_nxt, done_nxt, cfg_err_nxt;

  logic hold;
  logic accept;
  logic reject;
  logic kill;
  logic infinite;
  logic last_ctx;
  logic final_ctx;

`ifdef PE_CTX_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign accept    = go && load_done && !abort &&
                     (ctx_len != '0) && (ctx_len <= MAX_LEN);
  // A falling load_done means the cache is being reloaded: same as abort.
  assign kill      = abort || !load_done;
  assign infinite  = (iter_q == '0);
  assign last_ctx  = (CP == (len_q - CP_ONE));
  assign final_ctx = last_ctx && !infinite && (rem_q == ITER_ONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      len_q  <= '0;
      iter_q <= '0;
      rem_q  <= '0;
    end else begin
      state  <= state_nxt;
      len_q  <= len_nxt;
      iter_q <= iter_nxt;
      rem_q  <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    iter_nxt  = iter_q;
    rem_nxt   = rem_q;
    cp_nxt    = CP;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        cp_nxt = '0;
        if (go) begin
          if (accept) begin
            state_nxt = RUN;
            len_nxt   = ctx_len;
            iter_nxt  = iter_cnt;
            rem_nxt   = iter_cnt;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort takes priority over stall, wrap and completion.
        if (kill) begin
          state_nxt = IDLE;
          cp_nxt    = '0;
        end else if (!hold) begin
          if (last_ctx) begin
            cp_nxt = '0;
            if (final_ctx) begin
              state_nxt = DONE;
            end else if (!infinite) begin
              rem_nxt = rem_q - ITER_ONE;
            end
          end else begin
            cp_nxt = CP + CP_ONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cp_nxt    = '0;
      end
      default: begin
        state_nxt = IDLE;
        cp_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    busy_nxt    = (state_nxt == RUN);
    valid_nxt   = (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
    cfg_err_nxt = reject;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CP        <= '0;
      ctx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      CP        <= cp_nxt;
      ctx_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_err   <= cfg_err_nxt;
    end
  end

  a_cp_range: assert property (@(posedge CLK) disable iff (!RST_N) CP < MAX_LEN);
  a_valid_busy: assert property (@(posedge CLK) disable iff (!RST_N) ctx_valid == busy);
  a_done_pulse: assert property (@(posedge CLK) disable iff (!RST_N) done |=> !done);
  a_idle_cp: assert property (@(posedge CLK) disable iff (!RST_N) !busy |-> (CP == '0));

endmodule

`default_nettype wire
